// File: rtl/axi_stream_lane_converter_if.sv
// axi_stream_if: lane-parallel stream bus (data per lane, per-lane mask, packet last).
interface axi_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PAR        = 4
);
  logic                           valid;
  logic                           ready;
  logic                           last;
  logic [PAR-1:0][DATA_WIDTH-1:0] data;
  logic [PAR-1:0]                 mask;
  modport master (output valid, data, mask, last, input ready);
  modport slave  (input valid, data, mask, last, output ready);
endinterface

// File: rtl/axi_stream_lane_converter.sv
// axi_stream_lane_converter: packs (upsize), splits (downsize) or re-registers stream beats
// between lane counts; all m_axis outputs come straight from registers.
module axi_stream_lane_converter #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_PAR     = 4,
  parameter int OUT_PAR    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  axi_stream_if.slave  s_axis,
  axi_stream_if.master m_axis
);
  if (IN_PAR < 1 || OUT_PAR < 1 || (OUT_PAR % IN_PAR != 0 && IN_PAR % OUT_PAR != 0)) begin : g_bad
    $error("axi_stream_lane_converter: lane ratio must be an integer");
  end

  logic                            valid_q, last_q;
  logic [OUT_PAR*DATA_WIDTH-1:0]   data_q;
  logic [OUT_PAR-1:0]              mask_q;
  logic [IN_PAR*DATA_WIDTH-1:0]    s_data;
  logic                            fire, can_load;

  assign s_data        = s_axis.data;
  assign fire          = s_axis.valid && s_axis.ready;
  assign can_load      = !valid_q || m_axis.ready;
  assign m_axis.valid  = valid_q;
  assign m_axis.data   = data_q;
  assign m_axis.mask   = mask_q;
  assign m_axis.last   = last_q;

  if (OUT_PAR > IN_PAR) begin : g_up
    localparam int K  = OUT_PAR / IN_PAR;
    localparam int IW = $clog2(K);
    localparam int BW = IN_PAR * DATA_WIDTH;
    logic [IW-1:0]                 idx_q;
    logic [OUT_PAR*DATA_WIDTH-1:0] acc_data_q, word_data_d;
    logic [OUT_PAR-1:0]            acc_mask_q, word_mask_d;
    logic                          done;
    // Unwritten lanes stay zero because the accumulator is cleared on every completion.
    always_comb begin
      word_data_d = acc_data_q;
      word_mask_d = acc_mask_q;
      word_data_d[int'(idx_q)*BW +: BW]         = s_data;
      word_mask_d[int'(idx_q)*IN_PAR +: IN_PAR] = s_axis.mask;
    end
    assign done         = idx_q == IW'(K-1) || s_axis.last;
    assign s_axis.ready = rst_n && (!done || can_load);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q    <= 1'b0;
        last_q     <= 1'b0;
        data_q     <= '0;
        mask_q     <= '0;
        idx_q      <= '0;
        acc_data_q <= '0;
        acc_mask_q <= '0;
      end else begin
        if (valid_q && m_axis.ready) valid_q <= 1'b0;
        if (fire) begin
          acc_data_q <= done ? '0 : word_data_d;
          acc_mask_q <= done ? '0 : word_mask_d;
          idx_q      <= done ? '0 : idx_q + 1'b1;
          if (done) begin
            valid_q <= 1'b1;
            data_q  <= word_data_d;
            mask_q  <= word_mask_d;
            last_q  <= s_axis.last;
          end
        end
      end
    end
  end else if (IN_PAR > OUT_PAR) begin : g_down
    localparam int K  = IN_PAR / OUT_PAR;
    localparam int JW = $clog2(K);
    localparam int SW = OUT_PAR * DATA_WIDTH;
    logic [IN_PAR*DATA_WIDTH-1:0] hold_data_q;
    logic [IN_PAR-1:0]            hold_mask_q;
    logic                         hold_last_q, hv_q;
    logic [JW-1:0]                j_q, t_q, tsel;
    logic [SW-1:0]                slice_data;
    logic [OUT_PAR-1:0]           slice_mask;
    logic                         issue;
    // tsel is the final slice to emit: the highest populated one on a last beat, else all.
    always_comb begin
      tsel = '0;
      for (int i = 0; i < K; i++)
        if (|s_axis.mask[i*OUT_PAR +: OUT_PAR]) tsel = JW'(i);
      tsel = s_axis.last ? tsel : JW'(K-1);
    end
    assign slice_data   = hold_data_q[int'(j_q)*SW +: SW];
    assign slice_mask   = hold_mask_q[int'(j_q)*OUT_PAR +: OUT_PAR];
    assign issue        = hv_q && can_load;
    assign s_axis.ready = rst_n && (!hv_q || (j_q == t_q && can_load));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q     <= 1'b0;
        last_q      <= 1'b0;
        data_q      <= '0;
        mask_q      <= '0;
        hold_data_q <= '0;
        hold_mask_q <= '0;
        hold_last_q <= 1'b0;
        hv_q        <= 1'b0;
        j_q         <= '0;
        t_q         <= '0;
      end else begin
        if (valid_q && m_axis.ready) valid_q <= 1'b0;
        if (issue) begin
          valid_q <= 1'b1;
          data_q  <= slice_data;
          mask_q  <= slice_mask;
          last_q  <= hold_last_q && j_q == t_q;
          j_q     <= j_q + 1'b1;
          if (j_q == t_q) hv_q <= 1'b0;
        end
        if (fire) begin
          hold_data_q <= s_data;
          hold_mask_q <= s_axis.mask;
          hold_last_q <= s_axis.last;
          t_q         <= tsel;
          // From idle the first slice bypasses the holding register for one-cycle latency.
          if (!hv_q && can_load) begin
            valid_q <= 1'b1;
            data_q  <= s_data[SW-1:0];
            mask_q  <= s_axis.mask[OUT_PAR-1:0];
            last_q  <= s_axis.last && tsel == '0;
            j_q     <= JW'(1);
            hv_q    <= tsel != '0;
          end else begin
            j_q  <= '0;
            hv_q <= 1'b1;
          end
        end
      end
    end
  end else begin : g_eq
    assign s_axis.ready = rst_n && can_load;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
        mask_q  <= '0;
      end else begin
        if (valid_q && m_axis.ready) valid_q <= 1'b0;
        if (fire) begin
          valid_q <= 1'b1;
          data_q  <= s_data;
          mask_q  <= s_axis.mask;
          last_q  <= s_axis.last;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_stream_lane_converter.sv
// tb_axi_stream_lane_converter: four converters (4->8, 4->16, 8->2, 4->4) against a lane-level
// reference model, with a scoreboard monitor decoupled from the stimulus.
module tb_axi_stream_lane_converter;
  typedef struct packed {logic [127:0] d; logic [15:0] m; logic l;} beat_t;
  localparam int IP [4] = '{4, 4, 8, 4};
  localparam int OP [4] = '{8, 16, 2, 4};

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         s_valid [4], s_last [4], s_rdy [4], m_ready [4], m_valid [4];
  logic [127:0] s_data [4];
  logic [15:0]  s_mask [4];
  beat_t        m_beat [4];
  logic         hold_rdy = 1'b0, rnd_mode = 1'b0;
  logic [3:0]   rnd_bits = 4'hF;
  int           n_asrt = 0, n_fail = 0;
  int           hs_cnt [4] = '{0, 0, 0, 0};
  beat_t        exp_q [4][$];
  beat_t        acc [4];
  int           cnt [4] = '{0, 0, 0, 0};
  logic         pv [4], pr [4];
  beat_t        pb [4];
  beat_t        e;

  axi_stream_if #(.DATA_WIDTH(8), .PAR(4))  s0 ();
  axi_stream_if #(.DATA_WIDTH(8), .PAR(8))  m0 ();
  axi_stream_if #(.DATA_WIDTH(8), .PAR(4))  s1 ();
  axi_stream_if #(.DATA_WIDTH(8), .PAR(16)) m1 ();
  axi_stream_if #(.DATA_WIDTH(8), .PAR(8))  s2 ();
  axi_stream_if #(.DATA_WIDTH(8), .PAR(2))  m2 ();
  axi_stream_if #(.DATA_WIDTH(8), .PAR(4))  s3 ();
  axi_stream_if #(.DATA_WIDTH(8), .PAR(4))  m3 ();

  axi_stream_lane_converter #(.DATA_WIDTH(8), .IN_PAR(4), .OUT_PAR(8))
    dut0 (.clk(clk), .rst_n(rst_n), .s_axis(s0), .m_axis(m0));
  axi_stream_lane_converter #(.DATA_WIDTH(8), .IN_PAR(4), .OUT_PAR(16))
    dut1 (.clk(clk), .rst_n(rst_n), .s_axis(s1), .m_axis(m1));
  axi_stream_lane_converter #(.DATA_WIDTH(8), .IN_PAR(8), .OUT_PAR(2))
    dut2 (.clk(clk), .rst_n(rst_n), .s_axis(s2), .m_axis(m2));
  axi_stream_lane_converter #(.DATA_WIDTH(8), .IN_PAR(4), .OUT_PAR(4))
    dut3 (.clk(clk), .rst_n(rst_n), .s_axis(s3), .m_axis(m3));

  assign s0.valid = s_valid[0]; assign s0.data = s_data[0][31:0]; assign s0.mask = s_mask[0][3:0];
  assign s1.valid = s_valid[1]; assign s1.data = s_data[1][31:0]; assign s1.mask = s_mask[1][3:0];
  assign s2.valid = s_valid[2]; assign s2.data = s_data[2][63:0]; assign s2.mask = s_mask[2][7:0];
  assign s3.valid = s_valid[3]; assign s3.data = s_data[3][31:0]; assign s3.mask = s_mask[3][3:0];
  assign s0.last = s_last[0]; assign s1.last = s_last[1]; assign s2.last = s_last[2]; assign s3.last = s_last[3];
  assign s_rdy[0] = s0.ready; assign s_rdy[1] = s1.ready; assign s_rdy[2] = s2.ready; assign s_rdy[3] = s3.ready;
  assign m0.ready = m_ready[0]; assign m1.ready = m_ready[1]; assign m2.ready = m_ready[2]; assign m3.ready = m_ready[3];
  assign m_valid[0] = m0.valid; assign m_valid[1] = m1.valid; assign m_valid[2] = m2.valid; assign m_valid[3] = m3.valid;
  assign m_beat[0] = {128'(m0.data), 16'(m0.mask), m0.last};
  assign m_beat[1] = {128'(m1.data), 16'(m1.mask), m1.last};
  assign m_beat[2] = {128'(m2.data), 16'(m2.mask), m2.last};
  assign m_beat[3] = {128'(m3.data), 16'(m3.mask), m3.last};
  assign m_ready[0] = !hold_rdy && (!rnd_mode || rnd_bits[0]);
  assign m_ready[1] = !hold_rdy && (!rnd_mode || rnd_bits[1]);
  assign m_ready[2] = !hold_rdy && (!rnd_mode || rnd_bits[2]);
  assign m_ready[3] = !hold_rdy && (!rnd_mode || rnd_bits[3]);

  always @(posedge clk) begin
    #1;
    rnd_bits = 4'($urandom);
  end

  task automatic chk(input string nm, input logic [144:0] act, input logic [144:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic beat_t lanes(input beat_t b, input int lo, input int n);
    beat_t r = '0;
    for (int i = 0; i < n; i++) begin
      r.d[i*8 +: 8] = b.d[(lo+i)*8 +: 8];
      r.m[i]        = b.m[lo+i];
    end
    return r;
  endfunction

  // Reference: a packet is a sequence of lanes; outputs are regrouped lanes.
  task automatic model(input int i, input beat_t b);
    beat_t o;
    int k, t;
    if (OP[i] > IP[i]) begin
      k = OP[i] / IP[i];
      for (int n = 0; n < IP[i]; n++) begin
        acc[i].d[(cnt[i]*IP[i]+n)*8 +: 8] = b.d[n*8 +: 8];
        acc[i].m[cnt[i]*IP[i]+n]          = b.m[n];
      end
      cnt[i]++;
      if (cnt[i] == k || b.l) begin
        o = acc[i];
        o.l = b.l;
        exp_q[i].push_back(o);
        acc[i] = '0;
        cnt[i] = 0;
      end
    end else if (IP[i] > OP[i]) begin
      k = IP[i] / OP[i];
      t = b.l ? 0 : k - 1;
      if (b.l) for (int j = 0; j < k; j++) if (lanes(b, j*OP[i], OP[i]).m != 0) t = j;
      for (int j = 0; j <= t; j++) begin
        o = lanes(b, j*OP[i], OP[i]);
        o.l = b.l && j == t;
        exp_q[i].push_back(o);
      end
    end else exp_q[i].push_back(b);
  endtask

  task automatic send(input int i, input beat_t b);
    int  w = 0;
    bit  ok = 0;
    s_valid[i] = 1'b1; s_data[i] = b.d; s_mask[i] = b.m; s_last[i] = b.l;
    while (!ok) begin
      @(negedge clk);
      ok = s_rdy[i];
      if (ok) model(i, b);
      @(posedge clk); #1;
      if (!ok && ++w > 300) begin
        chk("send_timeout", 145'(i), 145'(99));
        break;
      end
    end
    s_valid[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) pv[i] = 1'b0;
      else begin
        if (pv[i] && !pr[i]) begin
          chk("stall_valid", 145'(m_valid[i]), 145'(1));
          chk("stall_beat", m_beat[i], pb[i]);
        end
        if (m_valid[i] && m_ready[i]) begin
          hs_cnt[i]++;
          if (exp_q[i].size() == 0) chk("unexpected_beat", m_beat[i], '0);
          else begin
            e = exp_q[i].pop_front();
            chk("scoreboard", m_beat[i], e);
          end
        end
        pv[i] = m_valid[i]; pr[i] = m_ready[i]; pb[i] = m_beat[i];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    beat_t  b;
    int     c0, w;
    logic [127:0] lim;
    for (int i = 0; i < 4; i++) begin
      s_valid[i] = 1'b0; s_data[i] = '0; s_mask[i] = '0; s_last[i] = 1'b0;
      acc[i] = '0; pv[i] = 1'b0; pr[i] = 1'b0; pb[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_valid", 145'(m_valid[i]), 145'(0));
      chk("reset_beat", m_beat[i], '0);
      chk("reset_s_ready", 145'(s_rdy[i]), 145'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, '{d: 128'h03020100, m: 16'hF, l: 1'b0});
    send(0, '{d: 128'h07060504, m: 16'hF, l: 1'b1});
    chk("up4_8_latency", 145'(m_valid[0]), 145'(1));
    chk("up4_8_word", m_beat[0], {128'h0706050403020100, 16'hFF, 1'b1});

    for (int n = 0; n < 5; n++) send(1, '{d: 128'($urandom), m: 16'hF, l: n == 4});
    chk("up4_16_mask", 145'(m_beat[1].m), 145'(16'h000F));
    chk("up4_16_last", 145'(m_beat[1].l), 145'(1));
    chk("up4_16_zero_lanes", 145'(m_beat[1].d[127:32]), 145'(0));

    c0 = hs_cnt[2];
    send(2, '{d: 128'h0F0E0D0C0B0A0908, m: 16'h3F, l: 1'b1});
    repeat (8) @(posedge clk);
    #1;
    chk("down_last_count", 145'(hs_cnt[2] - c0), 145'(3));
    c0 = hs_cnt[2];
    send(2, '{d: 128'h1716151413121110, m: 16'h0F, l: 1'b0});
    repeat (8) @(posedge clk);
    #1;
    chk("down_nonlast_count", 145'(hs_cnt[2] - c0), 145'(4));

    hold_rdy = 1'b1;
    send(0, '{d: 128'h11111111, m: 16'hF, l: 1'b0});
    send(0, '{d: 128'h22222222, m: 16'hF, l: 1'b1});
    send(1, '{d: 128'h33333333, m: 16'hF, l: 1'b0});
    send(1, '{d: 128'h44444444, m: 16'hF, l: 1'b0});
    chk("pre_reset_stalled", 145'(m_valid[0]), 145'(1));
    #3 rst_n = 1'b0;
    #1 chk("async_reset_valid", 145'(m_valid[0]), 145'(0));
    chk("reset_s_ready_low", 145'(s_rdy[1]), 145'(0));
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      acc[i] = '0;
      cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_rdy = 1'b0;
    @(posedge clk); #1;
    send(1, '{d: 128'h5A5B5C5D, m: 16'hF, l: 1'b1});
    chk("post_reset_lane0", m_beat[1], {128'h5A5B5C5D, 16'h000F, 1'b1});

    rnd_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lim = (128'd1 << (IP[i]*8)) - 1;
      for (int n = 0; n < 200; n++) begin
        b.d = {$urandom, $urandom, $urandom, $urandom} & lim;
        b.m = 16'($urandom) & 16'((1 << IP[i]) - 1);
        b.l = $urandom_range(0, 7) == 0;
        send(i, b);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
      send(i, '{d: '0, m: '0, l: 1'b1});
      w = 0;
      while (exp_q[i].size() != 0 && w < 500) begin
        @(posedge clk);
        w++;
      end
      #1;
      chk("drain_empty", 145'(exp_q[i].size()), 145'(0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
